boot_loader: RTL

//   Upstream program loader for the single-cycle core. Receives a byte stream, assembles

---
 rtl/boot_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Serial program loader: parses a count/payload/checksum byte stream, writes the
// payload into main memory word by word, and releases the core only on a verified image.
module boot_loader #(
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] BASE_ADDR    = '0,
  parameter int unsigned             MAX_WORDS    = 2**(ADDRESS_BITS-2)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  output logic                    core_reset,
  output logic                    done,
  output logic                    error,
  output logic [ADDRESS_BITS-1:0] words_loaded
);

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    CHECK,
    RUN,
    ERR
  } state_t;

  localparam logic [32:0] MAX_WORDS_EXT = 33'(MAX_WORDS);

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] byte_shift;
  logic [31:0] n_words;
  logic [31:0] checksum;

  logic        transfer;
  logic        last_byte;
  logic [31:0] word_in;

  // The fourth byte is merged straight from rx_data so each field is acted on
  // in the same cycle its last byte arrives.
  assign transfer  = rx_valid && rx_ready;
  assign last_byte = transfer && (byte_idx == 2'd3);
  assign word_in   = {rx_data, byte_shift};

  // NOTE: every register here uses <= so all updates land together on the edge;
  // the reset branch clears every register, so nothing powers up undefined.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= HDR;
      byte_idx       <= 2'd0;
      byte_shift     <= '0;
      n_words        <= '0;
      checksum       <= '0;
      rx_ready       <= 1'b0;
      mem_wEn        <= 1'b0;
      mem_address    <= BASE_ADDR;
      mem_write_data <= '0;
      core_reset     <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
    end else begin
      mem_wEn <= 1'b0;

      if (transfer) begin
        byte_shift <= {rx_data, byte_shift[23:8]};
        byte_idx   <= byte_idx + 2'd1;
      end

      case (state)
        HDR: begin
          rx_ready <= 1'b1;
          if (last_byte) begin
            n_words <= word_in;
            if ({1'b0, word_in} > MAX_WORDS_EXT) begin
              state    <= ERR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else if (word_in == 32'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          rx_ready <= 1'b1;
          if (last_byte) begin
            state          <= WRITE;
            rx_ready       <= 1'b0;
            mem_wEn        <= 1'b1;
            mem_address    <= BASE_ADDR + {words_loaded[ADDRESS_BITS-3:0], 2'b00};
            mem_write_data <= word_in;
          end
        end

        WRITE: begin
          checksum     <= checksum ^ mem_write_data;
          words_loaded <= words_loaded + ADDRESS_BITS'(1);
          rx_ready     <= 1'b1;
          if (32'(words_loaded) + 32'd1 == n_words) begin
            state <= CHECK;
          end else begin
            state <= DATA;
          end
        end

        CHECK: begin
          rx_ready <= 1'b1;
          if (last_byte) begin
            rx_ready <= 1'b0;
            if (word_in == checksum) begin
              state      <= RUN;
              core_reset <= 1'b0;
              done       <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end

        RUN: begin
          rx_ready   <= 1'b0;
          core_reset <= 1'b0;
          done       <= 1'b1;
        end

        ERR: begin
          rx_ready   <= 1'b0;
          core_reset <= 1'b1;
          error      <= 1'b1;
        end

        default: begin
          state    <= ERR;
          rx_ready <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule
